core_lsu_axil: RTL and testbench
================================

Name: core_lsu_axil

Overview:
- Parametrised AXI4-Lite load/store unit: next-generation data-memory port between the execute stage and the data bus.
- Accepts one load or store per REQ_VALID/REQ_READY handshake and captures it internally, so pipeline inputs need not be held.
- Generates byte strobes and lane shifting from address and access size, and sign/zero-extends load data.
- Reports OKAY, misaligned, bus-error and timeout outcomes on a single-cycle response strobe; AW and W handshakes complete independently.

Parameters:
- AXI_AWIDTH, 32, bus address width; values 12..32.
- AXI_DWIDTH, 32, bus data width; 32 or 64. LANES = AXI_DWIDTH/8, OFFW = log2(LANES).
- TIMEOUT_CYCLES, 256, cycles allowed in a bus state before abort; 0 disables the timeout.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  request accepted when REQ_VALID & REQ_READY.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_SIZE  in  2  00 = byte, 01 = half, 10 = word, 11 = dword (64-bit bus only).
- REQ_UNSIGNED  in  1  load zero-extends when 1, sign-extends when 0.
- REQ_ADDR  in  32  byte address (rs1 + imm).
- REQ_WDATA  in  AXI_DWIDTH  store data, right-aligned.
- RSP_VALID  out  1  one-cycle completion pulse.
- RSP_ERR  out  2  00 = ok, 01 = misaligned, 10 = bus error, 11 = timeout.
- RSP_RDATA  out  AXI_DWIDTH  extended load data; 0 for stores and on any error.
- BUSY  out  1  state != IDLE.
- AXI_AWADDR/AWVALID/AWREADY, AXI_WDATA/WSTRB(LANES)/WVALID/WREADY, AXI_BRESP/BVALID/BREADY, AXI_ARADDR/ARVALID/ARREADY, AXI_RDATA/RRESP/RVALID/RREADY: AXI4-Lite master, widths per parameters.

Behaviour:
- Reset values: every AXI VALID/READY output 0, RSP_VALID 0, RSP_ERR 00, RSP_RDATA 0, addresses/WDATA/WSTRB 0, state IDLE, timeout counter 0. Reset mid-transaction drops all valids the next cycle, produces no RSP, and returns to IDLE.
- REQ_READY = (state == IDLE) & !RST. The accept cycle registers REQ_* fields.
- Misaligned: address offset not a multiple of the size, or size 11 on a 32-bit bus. No bus traffic; RSP_VALID with ERR=01 the cycle after accept.
- FSM states: IDLE, RD, WR, WB, RSP.
- IDLE -> RD (load) or WR (store) on an aligned accept.
- RD: ARVALID=1 until ARREADY is seen, then 0. RREADY=1 for the whole state, including the cycle of the AR handshake. On RVALID, capture RDATA/RRESP and go to RSP.
- WR: AWVALID and WVALID are asserted together. Each drops independently after its own handshake. Go to WB when both are done, which may be the same cycle.
- WB: BREADY=1. On BVALID, capture BRESP and go to RSP.
- RSP: RSP_VALID=1 for exactly one cycle, then IDLE. The next request can be accepted in the following cycle.
- Best-case latency: load accept -> ARVALID +1 -> RSP_VALID +1 after the R beat. Store: RSP_VALID +1 after the B beat.
- AXI addresses = captured address with low OFFW bits cleared, truncated to AXI_AWIDTH.
- WSTRB = mask(size) << offset, where mask = 1, 3, F, FF.
- WDATA = REQ_WDATA << (8*offset).
- Load data: shift = RDATA >> (8*offset), take the low 8/16/32/64 bits, then extend per REQ_UNSIGNED.
- Bus error: RRESP or BRESP != 00 gives ERR=10 and RSP_RDATA=0.
- Timeout counter: cleared on entering RD or WR, counts during RD/WR/WB. At TIMEOUT_CYCLES-1: deassert all valids/readys, go to RSP with ERR=11. This is a debug abort and intentionally breaks the AXI protocol; the bus must be reset afterwards.
- Address and data outputs are stable while the corresponding VALID is high.

Test Plan:
- Word load at 0x100, ARREADY and RVALID in the same cycle, RDATA=0x8899AABB -> ARADDR=0x100, RSP_VALID 1 cycle later, RSP_RDATA=0x8899AABB, ERR=00.
- Signed byte load at 0x103, RDATA=0x80FF0000 -> RSP_RDATA=0xFFFFFF80; the same access with REQ_UNSIGNED=1 -> 0x00000080.
- Half store 0x1234 at 0x202; AWREADY 2 cycles before WREADY -> AWADDR=0x200, WSTRB=1100, WDATA=0x12340000. AWVALID drops while WVALID is still held; RSP after BVALID with ERR=00.
- Word load at 0x101 -> no ARVALID, RSP_VALID the cycle after accept, ERR=01, RSP_RDATA=0.
- Store with BRESP=10 -> ERR=10. Load with ARREADY held 0 and TIMEOUT_CYCLES=8 -> ARVALID drops after 8 cycles, ERR=11.
- RST asserted during WR with AWVALID high -> all valids 0 next cycle, no RSP_VALID, REQ_READY=1 after release.

Source files
------------

// File: rtl/core_lsu_axil.sv
// -----------------------------------------------------------------------------
// core_lsu_axil
//   AXI4-Lite load/store unit sitting between the execute stage and the data
//   bus. One load or store is accepted per REQ_VALID/REQ_READY handshake and
//   captured internally. Byte strobes and lane shifting are derived from the
//   address offset and access size; load data is sign- or zero-extended.
//   Every request ends in a single-cycle RSP_VALID pulse carrying the outcome.
//
// Ports
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   REQ_*               request channel from the pipeline (valid/ready)
//   RSP_VALID/ERR/RDATA one-cycle completion strobe, status and load data
//   BUSY                unit is not idle
//   AXI_AW*/W*/B*       AXI4-Lite write address / data / response (master)
//   AXI_AR*/R*          AXI4-Lite read address / data (master)
// -----------------------------------------------------------------------------
module core_lsu_axil #(
   parameter int AXI_AWIDTH     = 32,
   parameter int AXI_DWIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      REQ_VALID,
   output logic                      REQ_READY,
   input  logic                      REQ_WE,
   input  logic [1:0]                REQ_SIZE,
   input  logic                      REQ_UNSIGNED,
   input  logic [31:0]               REQ_ADDR,
   input  logic [AXI_DWIDTH-1:0]     REQ_WDATA,
   output logic                      RSP_VALID,
   output logic [1:0]                RSP_ERR,
   output logic [AXI_DWIDTH-1:0]     RSP_RDATA,
   output logic                      BUSY,
   output logic [AXI_AWIDTH-1:0]     AXI_AWADDR,
   output logic                      AXI_AWVALID,
   input  logic                      AXI_AWREADY,
   output logic [AXI_DWIDTH-1:0]     AXI_WDATA,
   output logic [AXI_DWIDTH/8-1:0]   AXI_WSTRB,
   output logic                      AXI_WVALID,
   input  logic                      AXI_WREADY,
   input  logic [1:0]                AXI_BRESP,
   input  logic                      AXI_BVALID,
   output logic                      AXI_BREADY,
   output logic [AXI_AWIDTH-1:0]     AXI_ARADDR,
   output logic                      AXI_ARVALID,
   input  logic                      AXI_ARREADY,
   input  logic [AXI_DWIDTH-1:0]     AXI_RDATA,
   input  logic [1:0]                AXI_RRESP,
   input  logic                      AXI_RVALID,
   output logic                      AXI_RREADY
);

   localparam int LANES = AXI_DWIDTH / 8;
   localparam int OFFW  = $clog2(LANES);
   localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_WR   = 3'd2;
   localparam logic [2:0] S_WB   = 3'd3;
   localparam logic [2:0] S_RSP  = 3'd4;

   localparam logic [1:0] E_OK   = 2'b00;
   localparam logic [1:0] E_MIS  = 2'b01;
   localparam logic [1:0] E_BUS  = 2'b10;
   localparam logic [1:0] E_TMO  = 2'b11;

   // offset must be a multiple of the access size; dword exists only on 64-bit
   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
      case (size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = off[0];
         2'b10:   misaligned = |off[1:0];
         default: misaligned = (LANES == 4) || (|off);
      endcase
   endfunction

   function automatic logic [LANES-1:0] strb_of(input logic [1:0] size, input logic [OFFW-1:0] off);
      logic [7:0] m;
      case (size)
         2'b00:   m = 8'h01;
         2'b01:   m = 8'h03;
         2'b10:   m = 8'h0f;
         default: m = 8'hff;
      endcase
      strb_of = LANES'(m) << off;
   endfunction

   // Extension is done at 64 bits and truncated so one body serves both widths.
   function automatic logic [AXI_DWIDTH-1:0] load_ext(input logic [AXI_DWIDTH-1:0] rdata,
                                                     input logic [1:0] size,
                                                     input logic uns,
                                                     input logic [OFFW-1:0] off);
      logic [AXI_DWIDTH-1:0] sh;
      logic [63:0]           w;
      logic [63:0]           r;
      sh = rdata >> {off, 3'b000};
      w  = 64'(sh);
      case (size)
         2'b00:   r = {{56{~uns & w[7]}},  w[7:0]};
         2'b01:   r = {{48{~uns & w[15]}}, w[15:0]};
         2'b10:   r = {{32{~uns & w[31]}}, w[31:0]};
         default: r = w;
      endcase
      load_ext = AXI_DWIDTH'(r);
   endfunction

   logic [2:0]            state_q,   state_d;
   logic [1:0]            size_q,    size_d;
   logic                  uns_q,     uns_d;
   logic [OFFW-1:0]       off_q,     off_d;
   logic [AXI_AWIDTH-1:0] araddr_q,  araddr_d;
   logic [AXI_AWIDTH-1:0] awaddr_q,  awaddr_d;
   logic [AXI_DWIDTH-1:0] wdata_q,   wdata_d;
   logic [LANES-1:0]      wstrb_q,   wstrb_d;
   logic                  arvalid_q, arvalid_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q,  wvalid_d;
   logic [TW-1:0]         tmo_q,     tmo_d;
   logic [1:0]            err_q,     err_d;
   logic [AXI_DWIDTH-1:0] rdata_q,   rdata_d;

   logic [OFFW-1:0]       req_off;
   logic [AXI_AWIDTH-1:0] req_bus_addr;
   logic                  tmo_hit;
   logic                  aw_done;
   logic                  w_done;

   assign req_off      = REQ_ADDR[OFFW-1:0];
   assign req_bus_addr = {REQ_ADDR[AXI_AWIDTH-1:OFFW], {OFFW{1'b0}}};
   assign tmo_hit      = (TIMEOUT_CYCLES != 0) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
   assign aw_done      = ~awvalid_q | AXI_AWREADY;
   assign w_done       = ~wvalid_q  | AXI_WREADY;

   always_comb begin
      state_d   = state_q;
      size_d    = size_q;
      uns_d     = uns_q;
      off_d     = off_q;
      araddr_d  = araddr_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      arvalid_d = arvalid_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      rdata_d   = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (REQ_VALID) begin
               size_d = REQ_SIZE;
               uns_d  = REQ_UNSIGNED;
               off_d  = req_off;
               tmo_d  = '0;
               if (misaligned(REQ_SIZE, 3'(req_off))) begin
                  state_d = S_RSP;
                  err_d   = E_MIS;
                  rdata_d = '0;
               end else if (REQ_WE) begin
                  state_d   = S_WR;
                  awaddr_d  = req_bus_addr;
                  wdata_d   = REQ_WDATA << {req_off, 3'b000};
                  wstrb_d   = strb_of(REQ_SIZE, req_off);
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = S_RD;
                  araddr_d  = req_bus_addr;
                  arvalid_d = 1'b1;
               end
            end
         end

         S_RD: begin
            tmo_d = tmo_q + TW'(1);
            if (arvalid_q && AXI_ARREADY) arvalid_d = 1'b0;
            // a completing beat wins over a timeout landing in the same cycle
            if (AXI_RVALID) begin
               state_d   = S_RSP;
               arvalid_d = 1'b0;
               if (AXI_RRESP != 2'b00) begin
                  err_d   = E_BUS;
                  rdata_d = '0;
               end else begin
                  err_d   = E_OK;
                  rdata_d = load_ext(AXI_RDATA, size_q, uns_q, off_q);
               end
            end else if (tmo_hit) begin
               state_d   = S_RSP;
               arvalid_d = 1'b0;
               err_d     = E_TMO;
               rdata_d   = '0;
            end
         end

         S_WR: begin
            tmo_d = tmo_q + TW'(1);
            if (awvalid_q && AXI_AWREADY) awvalid_d = 1'b0;
            if (wvalid_q  && AXI_WREADY)  wvalid_d  = 1'b0;
            if (aw_done && w_done) begin
               state_d = S_WB;
            end else if (tmo_hit) begin
               state_d   = S_RSP;
               awvalid_d = 1'b0;
               wvalid_d  = 1'b0;
               err_d     = E_TMO;
               rdata_d   = '0;
            end
         end

         S_WB: begin
            tmo_d = tmo_q + TW'(1);
            if (AXI_BVALID) begin
               state_d = S_RSP;
               err_d   = (AXI_BRESP != 2'b00) ? E_BUS : E_OK;
               rdata_d = '0;
            end else if (tmo_hit) begin
               state_d = S_RSP;
               err_d   = E_TMO;
               rdata_d = '0;
            end
         end

         S_RSP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         size_q    <= '0;
         uns_q     <= 1'b0;
         off_q     <= '0;
         araddr_q  <= '0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         arvalid_q <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         tmo_q     <= '0;
         err_q     <= E_OK;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         size_q    <= size_d;
         uns_q     <= uns_d;
         off_q     <= off_d;
         araddr_q  <= araddr_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         arvalid_q <= arvalid_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign REQ_READY   = (state_q == S_IDLE) & ~RST;
   assign BUSY        = (state_q != S_IDLE);
   assign RSP_VALID   = (state_q == S_RSP);
   assign RSP_ERR     = err_q;
   assign RSP_RDATA   = rdata_q;

   assign AXI_ARADDR  = araddr_q;
   assign AXI_ARVALID = arvalid_q;
   assign AXI_RREADY  = (state_q == S_RD);
   assign AXI_AWADDR  = awaddr_q;
   assign AXI_AWVALID = awvalid_q;
   assign AXI_WDATA   = wdata_q;
   assign AXI_WSTRB   = wstrb_q;
   assign AXI_WVALID  = wvalid_q;
   assign AXI_BREADY  = (state_q == S_WB);

endmodule

// File: tb/tb_core_lsu_axil.sv
module tb_core_lsu_axil;

   logic        CLK = 1'b0;
   logic        RST;
   logic        REQ_VALID, REQ_READY, REQ_WE, REQ_UNSIGNED;
   logic [1:0]  REQ_SIZE;
   logic [31:0] REQ_ADDR, REQ_WDATA;
   logic        RSP_VALID, BUSY;
   logic [1:0]  RSP_ERR;
   logic [31:0] RSP_RDATA;
   logic [31:0] AXI_AWADDR, AXI_WDATA, AXI_ARADDR, AXI_RDATA;
   logic [3:0]  AXI_WSTRB;
   logic        AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY;
   logic [1:0]  AXI_BRESP, AXI_RRESP;
   logic        AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY;
   logic        AXI_RVALID, AXI_RREADY;

   int total = 0;
   int bad   = 0;

   core_lsu_axil #(.AXI_AWIDTH(32), .AXI_DWIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .CLK(CLK), .RST(RST),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
      .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_ADDR(REQ_ADDR),
      .REQ_WDATA(REQ_WDATA),
      .RSP_VALID(RSP_VALID), .RSP_ERR(RSP_ERR), .RSP_RDATA(RSP_RDATA), .BUSY(BUSY),
      .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
      .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID),
      .AXI_WREADY(AXI_WREADY),
      .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
      .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
      .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID),
      .AXI_RREADY(AXI_RREADY)
   );

   always #5 CLK = ~CLK;

   // advance one clock and settle 1 time unit past the rising edge
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
      REQ_VALID = 1'b1; REQ_WE = we; REQ_SIZE = size; REQ_UNSIGNED = uns;
      REQ_ADDR = addr; REQ_WDATA = wdata;
      step();
      REQ_VALID = 1'b0;
   endtask

   // aligned load, AR and R handshakes in the same cycle
   task automatic load(input string tag, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] rdata, input logic [1:0] rresp,
                       input logic [31:0] exp_araddr, input logic [31:0] exp_rdata,
                       input logic [1:0] exp_err);
      req(1'b0, size, uns, addr, 32'h0);
      chk({tag, ".arvalid"}, AXI_ARVALID, 1);
      chk({tag, ".araddr"},  AXI_ARADDR,  exp_araddr);
      AXI_ARREADY = 1'b1; AXI_RVALID = 1'b1; AXI_RDATA = rdata; AXI_RRESP = rresp;
      step();
      AXI_ARREADY = 1'b0; AXI_RVALID = 1'b0; AXI_RDATA = 32'h0; AXI_RRESP = 2'b00;
      chk({tag, ".rsp_valid"}, RSP_VALID, 1);
      chk({tag, ".rsp_err"},   RSP_ERR,   exp_err);
      chk({tag, ".rsp_rdata"}, RSP_RDATA, exp_rdata);
      step();
      chk({tag, ".rsp_pulse"}, RSP_VALID, 0);
   endtask

   int hi;

   initial begin
      RST = 1'b1;
      REQ_VALID = 0; REQ_WE = 0; REQ_SIZE = 0; REQ_UNSIGNED = 0; REQ_ADDR = 0; REQ_WDATA = 0;
      AXI_AWREADY = 0; AXI_WREADY = 0; AXI_BRESP = 0; AXI_BVALID = 0;
      AXI_ARREADY = 0; AXI_RDATA = 0; AXI_RRESP = 0; AXI_RVALID = 0;
      step(); step(); step();

      // reset state
      chk("rst.req_ready", REQ_READY,   0);
      chk("rst.arvalid",   AXI_ARVALID, 0);
      chk("rst.awvalid",   AXI_AWVALID, 0);
      chk("rst.wvalid",    AXI_WVALID,  0);
      chk("rst.rready",    AXI_RREADY,  0);
      chk("rst.bready",    AXI_BREADY,  0);
      chk("rst.rsp_valid", RSP_VALID,   0);
      chk("rst.rsp_err",   RSP_ERR,     0);
      chk("rst.rsp_rdata", RSP_RDATA,   0);
      chk("rst.awaddr",    AXI_AWADDR,  0);
      chk("rst.wstrb",     AXI_WSTRB,   0);
      chk("rst.busy",      BUSY,        0);
      RST = 1'b0;
      #1;
      chk("idle.req_ready", REQ_READY, 1);

      // word load, then byte/half loads exercising lane shift and extension
      load("lw100",  2'b10, 1'b0, 32'h100, 32'h8899AABB, 2'b00, 32'h100, 32'h8899AABB, 2'b00);
      load("lb103",  2'b00, 1'b0, 32'h103, 32'h80FF0000, 2'b00, 32'h100, 32'hFFFFFF80, 2'b00);
      load("lbu103", 2'b00, 1'b1, 32'h103, 32'h80FF0000, 2'b00, 32'h100, 32'h00000080, 2'b00);
      load("lh102",  2'b01, 1'b0, 32'h102, 32'hBEEF1234, 2'b00, 32'h100, 32'hFFFFBEEF, 2'b00);
      load("lhu102", 2'b01, 1'b1, 32'h102, 32'hBEEF1234, 2'b00, 32'h100, 32'h0000BEEF, 2'b00);
      load("lb101",  2'b00, 1'b0, 32'h101, 32'h00007F00, 2'b00, 32'h100, 32'h0000007F, 2'b00);
      load("lwerr",  2'b10, 1'b0, 32'h108, 32'h12345678, 2'b10, 32'h108, 32'h00000000, 2'b10);

      // half store, AWREADY two cycles ahead of WREADY
      req(1'b1, 2'b01, 1'b0, 32'h202, 32'h00001234);
      chk("sh.awvalid", AXI_AWVALID, 1);
      chk("sh.wvalid",  AXI_WVALID,  1);
      chk("sh.awaddr",  AXI_AWADDR,  32'h200);
      chk("sh.wstrb",   AXI_WSTRB,   4'b1100);
      chk("sh.wdata",   AXI_WDATA,   32'h12340000);
      AXI_AWREADY = 1'b1;
      step();
      AXI_AWREADY = 1'b0;
      chk("sh.aw_drop",  AXI_AWVALID, 0);
      chk("sh.w_held1",  AXI_WVALID,  1);
      step();
      chk("sh.w_held2",  AXI_WVALID,  1);
      chk("sh.wdata_st", AXI_WDATA,   32'h12340000);
      AXI_WREADY = 1'b1;
      step();
      AXI_WREADY = 1'b0;
      chk("sh.w_drop", AXI_WVALID, 0);
      chk("sh.bready", AXI_BREADY, 1);
      chk("sh.no_rsp", RSP_VALID,  0);
      AXI_BVALID = 1'b1; AXI_BRESP = 2'b00;
      step();
      AXI_BVALID = 1'b0;
      chk("sh.rsp_valid", RSP_VALID, 1);
      chk("sh.rsp_err",   RSP_ERR,   0);
      chk("sh.rsp_rdata", RSP_RDATA, 0);
      step();

      // byte store, both channels ready together, then a bus error response
      req(1'b1, 2'b00, 1'b0, 32'h301, 32'h000000A5);
      chk("sb.awaddr", AXI_AWADDR, 32'h300);
      chk("sb.wstrb",  AXI_WSTRB,  4'b0010);
      chk("sb.wdata",  AXI_WDATA,  32'h0000A500);
      AXI_AWREADY = 1'b1; AXI_WREADY = 1'b1;
      step();
      AXI_AWREADY = 1'b0; AXI_WREADY = 1'b0;
      chk("sb.aw_drop", AXI_AWVALID, 0);
      chk("sb.w_drop",  AXI_WVALID,  0);
      chk("sb.bready",  AXI_BREADY,  1);
      AXI_BVALID = 1'b1; AXI_BRESP = 2'b10;
      step();
      AXI_BVALID = 1'b0; AXI_BRESP = 2'b00;
      chk("sb.rsp_valid", RSP_VALID, 1);
      chk("sb.rsp_err",   RSP_ERR,   2'b10);
      step();

      // misaligned word load: no AR, immediate response
      req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
      chk("mis.arvalid",   AXI_ARVALID, 0);
      chk("mis.rsp_valid", RSP_VALID,   1);
      chk("mis.rsp_err",   RSP_ERR,     2'b01);
      chk("mis.rsp_rdata", RSP_RDATA,   0);
      step();
      chk("mis.req_ready", REQ_READY, 1);

      // dword on a 32-bit bus is always misaligned
      req(1'b1, 2'b11, 1'b0, 32'h400, 32'h11111111);
      chk("mis64.awvalid", AXI_AWVALID, 0);
      chk("mis64.rsp_err", RSP_ERR,     2'b01);
      step();

      // load timeout with ARREADY stuck low
      req(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
      hi = 0;
      while (AXI_ARVALID === 1'b1 && hi < 20) begin
         hi++;
         step();
      end
      chk("tmo.ar_cycles", hi, 8);
      chk("tmo.rsp_valid", RSP_VALID,  1);
      chk("tmo.rsp_err",   RSP_ERR,    2'b11);
      chk("tmo.rready",    AXI_RREADY, 0);
      step();
      chk("tmo.idle", REQ_READY, 1);

      // reset while a store is waiting in WR
      req(1'b1, 2'b10, 1'b0, 32'h600, 32'hCAFEF00D);
      chk("rstwr.awvalid", AXI_AWVALID, 1);
      RST = 1'b1;
      step();
      chk("rstwr.awvalid0", AXI_AWVALID, 0);
      chk("rstwr.wvalid0",  AXI_WVALID,  0);
      chk("rstwr.no_rsp",   RSP_VALID,   0);
      chk("rstwr.busy",     BUSY,        0);
      RST = 1'b0;
      #1;
      chk("rstwr.req_ready", REQ_READY, 1);
      step();
      chk("rstwr.no_rsp2", RSP_VALID, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
